minimig_sram_arbiter: RTL and testbench

Two-port arbiter that shares the chipset SRAM bridge port between the chipset DMA requester and a host requester (OSD/SPI loader or CPU-side memory port). It decodes the 7.09 MHz bus phase from the c1/c3 clock enables, grants at most one access per four-phase bus cycle, and drives the bridge's bank, address, data and strobe inputs. It returns read data and a one-clock acknowledge to the granted requester. It sits directly in front of minimig_sram_bridge, in the 28 MHz clk domain.

---
 rtl/minimig_sram_arb_pkg.sv | 21 ++
 rtl/minimig_bus_phase.sv | 18 +
 rtl/minimig_sram_arbiter.sv | 206 ++++++++++++++++++++
 tb/tb_minimig_sram_arbiter.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/minimig_sram_arb_pkg.sv
// Shared types for the chipset SRAM arbiter: bus phase, arbiter state and grant codes.
package minimig_sram_arb_pkg;

    typedef enum logic [1:0] {
        Q0 = 2'd0,
        Q1 = 2'd1,
        Q2 = 2'd2,
        Q3 = 2'd3
    } phase_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CHIP = 2'd1,
        HOST = 2'd2
    } arb_state_e;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_CHIP = 2'b01;
    localparam logic [1:0] GNT_HOST = 2'b10;

endpackage

// File: rtl/minimig_bus_phase.sv
// Decodes the c1/c3 clock enables into a one-hot 7.09 MHz bus phase (bit index = phase_e).
module minimig_bus_phase
    import minimig_sram_arb_pkg::*;
(
    input  logic       c1,
    input  logic       c3,
    output logic [3:0] phase
);

    always_comb begin
        phase     = '0;
        phase[Q0] = !c1 && !c3;
        phase[Q1] =  c1 && !c3;
        phase[Q2] =  c1 &&  c3;
        phase[Q3] = !c1 &&  c3;
    end

endmodule

// File: rtl/minimig_sram_arbiter.sv
// Chip/host arbiter in front of minimig_sram_bridge; one access per four-phase bus cycle.
// Optional host anti-starvation counter: define MINIMIG_SRAM_ARB_STARVE_EN.
module minimig_sram_arbiter
    import minimig_sram_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        c1,
    input  logic        c3,
    input  logic        chip_req,
    input  logic [7:0]  chip_bank,
    input  logic [17:0] chip_addr,
    input  logic [15:0] chip_wdata,
    input  logic        chip_rd,
    input  logic        chip_hwr,
    input  logic        chip_lwr,
    output logic        chip_ack,
    output logic [15:0] chip_rdata,
    input  logic        host_req,
    input  logic [7:0]  host_bank,
    input  logic [17:0] host_addr,
    input  logic [15:0] host_wdata,
    input  logic        host_we,
    input  logic        host_ube,
    input  logic        host_lbe,
    output logic        host_ack,
    output logic [15:0] host_rdata,
    output logic [7:0]  bank,
    output logic [17:0] address_out,
    output logic [15:0] data_out,
    output logic        rd,
    output logic        hwr,
    output logic        lwr,
    input  logic [15:0] ramdata,
    output logic [1:0]  grant
);

    logic [3:0] phase;
    logic       q0_end;
    logic       q2_end;
    logic       unused_phase;

    minimig_bus_phase u_bus_phase (
        .c1    (c1),
        .c3    (c3),
        .phase (phase)
    );

    assign q0_end       = phase[Q0];
    assign q2_end       = phase[Q2];
    assign unused_phase = phase[Q1] ^ phase[Q3];

    arb_state_e  state_q, state_d;
    logic [1:0]  grant_q, grant_d;
    logic [7:0]  bank_q, bank_d;
    logic [17:0] addr_q, addr_d;
    logic [15:0] data_q, data_d;
    logic        rd_q, rd_d;
    logic        hwr_q, hwr_d;
    logic        lwr_q, lwr_d;
    logic        chip_ack_q, chip_ack_d;
    logic        host_ack_q, host_ack_d;
    logic [15:0] chip_rdata_q, chip_rdata_d;
    logic [15:0] host_rdata_q, host_rdata_d;
    logic        starve_hit;
    logic        host_win;

`ifdef MINIMIG_SRAM_ARB_STARVE_EN
    localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

    logic [STARVE_W-1:0] starve_q, starve_d;

    assign starve_hit = (starve_q == STARVE_MAX);

    // Counts chip grants the host sat through; any Q0 edge without a host request forgives it.
    always_comb begin
        starve_d = starve_q;
        if (q0_end) begin
            if (!host_req || host_win) begin
                starve_d = '0;
            end else if (chip_req && (starve_q != STARVE_MAX)) begin
                starve_d = starve_q + STARVE_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    logic unused_limit;

    assign starve_hit   = 1'b0;
    assign unused_limit = (STARVE_LIMIT == 0);
`endif

    assign host_win = host_req && (!chip_req || starve_hit);

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        bank_d       = bank_q;
        addr_d       = addr_q;
        data_d       = data_q;
        rd_d         = rd_q;
        hwr_d        = hwr_q;
        lwr_d        = lwr_q;
        chip_ack_d   = 1'b0;
        host_ack_d   = 1'b0;
        chip_rdata_d = chip_rdata_q;
        host_rdata_d = host_rdata_q;

        if (q0_end) begin
            if (host_win) begin
                state_d = HOST;
                grant_d = GNT_HOST;
                bank_d  = host_bank;
                addr_d  = host_addr;
                data_d  = host_wdata;
                rd_d    = !host_we;
                hwr_d   = host_we && host_ube;
                lwr_d   = host_we && host_lbe;
            end else if (chip_req) begin
                state_d = CHIP;
                grant_d = GNT_CHIP;
                bank_d  = chip_bank;
                addr_d  = chip_addr;
                data_d  = chip_wdata;
                rd_d    = chip_rd;
                hwr_d   = chip_hwr && !chip_rd;
                lwr_d   = chip_lwr && !chip_rd;
            end else begin
                state_d = IDLE;
                grant_d = GNT_NONE;
                bank_d  = '0;
                addr_d  = '0;
                data_d  = '0;
                rd_d    = 1'b0;
                hwr_d   = 1'b0;
                lwr_d   = 1'b0;
            end
        end

        // Only read slots refresh rdata, so a write leaves the last read value visible.
        if (q2_end) begin
            chip_ack_d = (state_q == CHIP);
            host_ack_d = (state_q == HOST);
            if (rd_q && (state_q == CHIP)) begin
                chip_rdata_d = ramdata;
            end
            if (rd_q && (state_q == HOST)) begin
                host_rdata_d = ramdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            grant_q      <= GNT_NONE;
            bank_q       <= '0;
            addr_q       <= '0;
            data_q       <= '0;
            rd_q         <= 1'b0;
            hwr_q        <= 1'b0;
            lwr_q        <= 1'b0;
            chip_ack_q   <= 1'b0;
            host_ack_q   <= 1'b0;
            chip_rdata_q <= '0;
            host_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            bank_q       <= bank_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            rd_q         <= rd_d;
            hwr_q        <= hwr_d;
            lwr_q        <= lwr_d;
            chip_ack_q   <= chip_ack_d;
            host_ack_q   <= host_ack_d;
            chip_rdata_q <= chip_rdata_d;
            host_rdata_q <= host_rdata_d;
        end
    end

    assign grant       = grant_q;
    assign bank        = bank_q;
    assign address_out = addr_q;
    assign data_out    = data_q;
    assign rd          = rd_q;
    assign hwr         = hwr_q;
    assign lwr         = lwr_q;
    assign chip_ack    = chip_ack_q;
    assign host_ack    = host_ack_q;
    assign chip_rdata  = chip_rdata_q;
    assign host_rdata  = host_rdata_q;

endmodule

// File: tb/tb_minimig_sram_arbiter.sv
// Self-checking bench for minimig_sram_arbiter: vector table, starvation/reset sequences, random slots.
module tb_minimig_sram_arbiter;

    localparam int unsigned LIMIT = 8;
`ifdef MINIMIG_SRAM_ARB_STARVE_EN
    localparam bit STARVE = 1'b1;
`else
    localparam bit STARVE = 1'b0;
`endif

    typedef struct packed {
        logic        chip_req;
        logic [7:0]  chip_bank;
        logic [17:0] chip_addr;
        logic [15:0] chip_wdata;
        logic        chip_rd;
        logic        chip_hwr;
        logic        chip_lwr;
        logic        host_req;
        logic [7:0]  host_bank;
        logic [17:0] host_addr;
        logic [15:0] host_wdata;
        logic        host_we;
        logic        host_ube;
        logic        host_lbe;
        logic [15:0] ramdata;
    } stim_t;

    typedef struct packed {
        logic [1:0]  grant;
        logic [7:0]  bank;
        logic [17:0] addr;
        logic [15:0] data;
        logic        rd;
        logic        hwr;
        logic        lwr;
        logic        chip_ack;
        logic        host_ack;
        logic [15:0] chip_rdata;
        logic [15:0] host_rdata;
    } exp_t;

    typedef struct packed {
        stim_t s;
        exp_t  e;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  ph = '0;
    logic        c1, c3;
    logic        chip_req, chip_rd, chip_hwr, chip_lwr;
    logic [7:0]  chip_bank;
    logic [17:0] chip_addr;
    logic [15:0] chip_wdata;
    logic        chip_ack;
    logic [15:0] chip_rdata;
    logic        host_req, host_we, host_ube, host_lbe;
    logic [7:0]  host_bank;
    logic [17:0] host_addr;
    logic [15:0] host_wdata;
    logic        host_ack;
    logic [15:0] host_rdata;
    logic [7:0]  bank;
    logic [17:0] address_out;
    logic [15:0] data_out;
    logic        rd, hwr, lwr;
    logic [15:0] ramdata;
    logic [1:0]  grant;

    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [15:0] m_chip_rdata = '0;
    logic [15:0] m_host_rdata = '0;
    int unsigned m_cnt = 0;

    always #5 clk = ~clk;
    always @(posedge clk) ph <= ph + 2'd1;
    assign c1 = ph[0] ^ ph[1];
    assign c3 = ph[1];

    minimig_sram_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .reset(reset), .c1(c1), .c3(c3),
        .chip_req(chip_req), .chip_bank(chip_bank), .chip_addr(chip_addr),
        .chip_wdata(chip_wdata), .chip_rd(chip_rd), .chip_hwr(chip_hwr),
        .chip_lwr(chip_lwr), .chip_ack(chip_ack), .chip_rdata(chip_rdata),
        .host_req(host_req), .host_bank(host_bank), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_we(host_we), .host_ube(host_ube),
        .host_lbe(host_lbe), .host_ack(host_ack), .host_rdata(host_rdata),
        .bank(bank), .address_out(address_out), .data_out(data_out),
        .rd(rd), .hwr(hwr), .lwr(lwr), .ramdata(ramdata), .grant(grant)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_q0();
        int unsigned n = 0;
        while (ph != 2'd0 && n < 8) begin
            @(negedge clk);
            n++;
        end
        if (ph != 2'd0) chk("phase_align", 32'(ph), 32'd0);
    endtask

    task automatic apply(input stim_t s);
        chip_req = s.chip_req;  chip_bank = s.chip_bank; chip_addr = s.chip_addr;
        chip_wdata = s.chip_wdata; chip_rd = s.chip_rd; chip_hwr = s.chip_hwr;
        chip_lwr = s.chip_lwr;
        host_req = s.host_req;  host_bank = s.host_bank; host_addr = s.host_addr;
        host_wdata = s.host_wdata; host_we = s.host_we; host_ube = s.host_ube;
        host_lbe = s.host_lbe;
    endtask

    // Runs one whole bus cycle: request at the Q0 edge, then checks Q1, Q2, Q3 and the closing Q0.
    task automatic do_slot(input string tag, input stim_t s, input exp_t e);
        wait_q0();
        apply(s);
        @(negedge clk);
        chk({tag, ".grant"}, 32'(grant), 32'(e.grant));
        chk({tag, ".bank"}, 32'(bank), 32'(e.bank));
        chk({tag, ".strobes"}, {29'd0, rd, hwr, lwr}, {29'd0, e.rd, e.hwr, e.lwr});
        if (e.grant != 2'b00) begin
            chk({tag, ".addr"}, 32'(address_out), 32'(e.addr));
            chk({tag, ".data"}, 32'(data_out), 32'(e.data));
        end
        chk({tag, ".ack_q1"}, {30'd0, chip_ack, host_ack}, 32'd0);
        @(negedge clk);
        ramdata = s.ramdata;
        chk({tag, ".ack_q2"}, {30'd0, chip_ack, host_ack}, 32'd0);
        @(negedge clk);
        chk({tag, ".ack_q3"}, {30'd0, chip_ack, host_ack}, {30'd0, e.chip_ack, e.host_ack});
        chk({tag, ".chip_rdata"}, 32'(chip_rdata), 32'(e.chip_rdata));
        chk({tag, ".host_rdata"}, 32'(host_rdata), 32'(e.host_rdata));
        @(negedge clk);
        chk({tag, ".ack_q0"}, {30'd0, chip_ack, host_ack}, 32'd0);
        chk({tag, ".bank_held"}, {24'd0, bank}, {24'd0, e.bank});
        m_chip_rdata = e.chip_rdata;
        m_host_rdata = e.host_rdata;
    endtask

    function automatic stim_t host_stim(input logic [7:0] b, input logic [17:0] a,
                                        input logic [15:0] wd, input logic we,
                                        input logic ube, input logic lbe, input logic [15:0] rdat);
        stim_t s = '0;
        s.host_req = 1'b1; s.host_bank = b; s.host_addr = a; s.host_wdata = wd;
        s.host_we = we; s.host_ube = ube; s.host_lbe = lbe; s.ramdata = rdat;
        return s;
    endfunction

    function automatic stim_t chip_stim(input logic [7:0] b, input logic [17:0] a,
                                        input logic [15:0] wd, input logic r,
                                        input logic hw, input logic lw, input logic [15:0] rdat);
        stim_t s = '0;
        s.chip_req = 1'b1; s.chip_bank = b; s.chip_addr = a; s.chip_wdata = wd;
        s.chip_rd = r; s.chip_hwr = hw; s.chip_lwr = lw; s.ramdata = rdat;
        return s;
    endfunction

    function automatic exp_t mk_exp(input logic [1:0] g, input logic [7:0] b, input logic [17:0] a,
                                    input logic [15:0] d, input logic r, input logic hw,
                                    input logic lw, input logic [15:0] crd, input logic [15:0] hrd);
        exp_t e;
        e.grant = g; e.bank = b; e.addr = a; e.data = d; e.rd = r; e.hwr = hw; e.lwr = lw;
        e.chip_ack = (g == 2'b01); e.host_ack = (g == 2'b10);
        e.chip_rdata = crd; e.host_rdata = hrd;
        return e;
    endfunction

    // Reference: decide the owner of a bus cycle from the priority/starvation rules.
    task automatic predict(input stim_t s, output exp_t e);
        bit host_w, chip_w;
        host_w = s.host_req && (!s.chip_req || (STARVE && m_cnt == LIMIT));
        chip_w = s.chip_req && !host_w;
        e = '0;
        e.chip_rdata = m_chip_rdata;
        e.host_rdata = m_host_rdata;
        if (host_w) begin
            e.grant = 2'b10; e.bank = s.host_bank; e.addr = s.host_addr; e.data = s.host_wdata;
            e.rd = !s.host_we; e.hwr = s.host_we && s.host_ube; e.lwr = s.host_we && s.host_lbe;
            e.host_ack = 1'b1;
            if (!s.host_we) e.host_rdata = s.ramdata;
        end else if (chip_w) begin
            e.grant = 2'b01; e.bank = s.chip_bank; e.addr = s.chip_addr; e.data = s.chip_wdata;
            e.rd = s.chip_rd; e.hwr = s.chip_hwr && !s.chip_rd; e.lwr = s.chip_lwr && !s.chip_rd;
            e.chip_ack = 1'b1;
            if (s.chip_rd) e.chip_rdata = s.ramdata;
        end
        if (!s.host_req || host_w) m_cnt = 0;
        else if (chip_w && m_cnt < LIMIT) m_cnt++;
    endtask

    vec_t  vecs[8];
    stim_t st;
    exp_t  ex;

    initial begin
        apply('0);
        ramdata = '0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst.grant", 32'(grant), 32'd0);
        chk("rst.bus", {bank, rd, hwr, lwr, chip_ack, host_ack}, 32'd0);
        chk("rst.addr_data", {address_out[15:0], data_out}, 32'd0);
        chk("rst.rdata", {chip_rdata, host_rdata}, 32'd0);
        reset = 1'b0;

        vecs[0].s = host_stim(8'h01, 18'h00123, 16'h0000, 1'b0, 1'b1, 1'b1, 16'hBEEF);
        vecs[0].e = mk_exp(2'b10, 8'h01, 18'h00123, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 16'hBEEF);
        vecs[1].s = host_stim(8'h02, 18'h30000, 16'h1234, 1'b1, 1'b1, 1'b0, 16'hDEAD);
        vecs[1].e = mk_exp(2'b10, 8'h02, 18'h30000, 16'h1234, 1'b0, 1'b1, 1'b0, 16'h0000, 16'hBEEF);
        vecs[2].s = chip_stim(8'h04, 18'h00456, 16'hAAAA, 1'b1, 1'b1, 1'b0, 16'h5555);
        vecs[2].e = mk_exp(2'b01, 8'h04, 18'h00456, 16'hAAAA, 1'b1, 1'b0, 1'b0, 16'h5555, 16'hBEEF);
        vecs[3].s = chip_stim(8'h00, 18'h3FFFF, 16'h0001, 1'b1, 1'b0, 1'b0, 16'h0000);
        vecs[3].e = mk_exp(2'b01, 8'h00, 18'h3FFFF, 16'h0001, 1'b1, 1'b0, 1'b0, 16'h0000, 16'hBEEF);
        vecs[4].s = host_stim(8'h03, 18'h00010, 16'h0F0F, 1'b1, 1'b0, 1'b0, 16'h4321);
        vecs[4].e = mk_exp(2'b10, 8'h03, 18'h00010, 16'h0F0F, 1'b0, 1'b0, 1'b0, 16'h0000, 16'hBEEF);
        vecs[5].s = chip_stim(8'h05, 18'h12345, 16'h9999, 1'b0, 1'b0, 1'b1, 16'h6666);
        vecs[5].e = mk_exp(2'b01, 8'h05, 18'h12345, 16'h9999, 1'b0, 1'b0, 1'b1, 16'h0000, 16'hBEEF);
        vecs[6].s = chip_stim(8'h06, 18'h00002, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h7070);
        vecs[6].s.host_req = 1'b1; vecs[6].s.host_bank = 8'h07;
        vecs[6].e = mk_exp(2'b01, 8'h06, 18'h00002, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h7070, 16'hBEEF);
        vecs[7].s = '0;
        vecs[7].s.ramdata = 16'h1111;
        vecs[7].e = mk_exp(2'b00, 8'h00, 18'h0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h7070, 16'hBEEF);

        for (int i = 0; i < 8; i++) begin
            do_slot($sformatf("vec%0d", i), vecs[i].s, vecs[i].e);
        end

        // Chip and host both held for ten slots; host only breaks through when starvation relief is built in.
        for (int i = 1; i <= 10; i++) begin
            st = chip_stim(8'h06, 18'(i), 16'h0000, 1'b1, 1'b0, 1'b0, 16'h1000 + 16'(i));
            st.host_req = 1'b1; st.host_bank = 8'h07; st.host_addr = 18'h00077;
            st.host_we = 1'b0; st.host_ube = 1'b1; st.host_lbe = 1'b1;
            if (STARVE && i == 9)
                ex = mk_exp(2'b10, 8'h07, 18'h00077, 16'h0000, 1'b1, 1'b0, 1'b0,
                            m_chip_rdata, 16'h1000 + 16'(i));
            else
                ex = mk_exp(2'b01, 8'h06, 18'(i), 16'h0000, 1'b1, 1'b0, 1'b0,
                            16'h1000 + 16'(i), m_host_rdata);
            do_slot($sformatf("starve%0d", i), st, ex);
        end

        // Reset during Q2 of a host read: bus clears, no ack, then service resumes.
        wait_q0();
        apply(host_stim(8'h08, 18'h00005, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0000));
        @(negedge clk);
        chk("rstmid.grant_q1", 32'(grant), 32'd2);
        chk("rstmid.bank_q1", 32'(bank), 32'h08);
        @(negedge clk);
        ramdata = 16'hCAFE;
        reset = 1'b1;
        @(negedge clk);
        chk("rstmid.bank", 32'(bank), 32'd0);
        chk("rstmid.grant", 32'(grant), 32'd0);
        chk("rstmid.strobes_ack", {28'd0, rd, hwr, lwr, host_ack}, 32'd0);
        chk("rstmid.rdata", 32'(host_rdata), 32'd0);
        host_req = 1'b0;
        @(negedge clk);
        chk("rstmid.ack_q0", 32'(host_ack), 32'd0);
        reset = 1'b0;
        m_chip_rdata = '0; m_host_rdata = '0; m_cnt = 0;
        do_slot("post_rst", host_stim(8'h09, 18'h00099, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h7777),
                mk_exp(2'b10, 8'h09, 18'h00099, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h7777));

        for (int i = 0; i < 150; i++) begin
            st = stim_t'({$urandom, $urandom, $urandom, $urandom});
            st.chip_req = ($urandom_range(9) < 6);
            st.host_req = ($urandom_range(9) < 8);
            predict(st, ex);
            do_slot($sformatf("rnd%0d", i), st, ex);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
